spi_slave_word: RTL
===================

SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bits per SPI word (legal range 2..32).
REQ-002 Parameter CPOL, default 1, SHALL set the SPI_clock idle level.
REQ-003 Parameter CPHA, default 1, SHALL select the data edges: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 Parameter FILL_WORD, default all-ones, SHALL set the word transmitted when no TX word is loaded.
REQ-005 clock  in  1  system clock; all logic SHALL run on its rising edge.
REQ-006 not_reset  in  1  asynchronous, active-low reset.
REQ-007 SPI_clock  in  1  asynchronous serial clock from the master.
REQ-008 SPI_in  in  1  asynchronous serial data from the master (MOSI).
REQ-009 SPI_out  out  1  serial data to the master (MISO).
REQ-010 SPI_not_chip_select  in  1  asynchronous, active-low select.
REQ-011 in_data_valid  out  1  received word held in in_data.
REQ-012 in_data  out  DATA_WIDTH  received word.
REQ-013 in_data_ready  in  1  consumer accepts in_data.
REQ-014 out_data_valid  in  1  producer offers out_data.
REQ-015 out_data  in  DATA_WIDTH  word to transmit.
REQ-016 out_data_ready  out  1  TX holding register empty.
REQ-017 active  out  1  synchronised chip select is low.
REQ-018 rx_overrun  out  1  one-cycle pulse when a received word was lost.

Function
REQ-019 SPI_clock, SPI_in and SPI_not_chip_select SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised value.
REQ-020 The leading edge SHALL be the edge leaving level CPOL; the sample edge SHALL be the leading edge if CPHA=0 and the trailing edge if CPHA=1; the shift edge SHALL be the other edge.
REQ-021 The FSM SHALL have states IDLE and XFER: IDLE->XFER on synchronised chip-select fall; any state->IDLE on synchronised chip-select rise; SPI_clock edges in IDLE SHALL be ignored.
REQ-022 Data SHALL be MSB first; a bit counter SHALL count 0..DATA_WIDTH-1 on sample edges and wrap to 0.
REQ-023 On the sample edge that completes a word, the RX shift value SHALL be copied to in_data, and in_data_valid SHALL assert on the next clock.
REQ-024 in_data_valid SHALL stay high and in_data SHALL stay stable until a cycle with in_data_ready=1, then deassert on the following clock.
REQ-025 If a word completes while in_data_valid=1 and in_data_ready=0, the behaviour is set by REQ-036/037; if in_data_ready=1 in that same cycle, the new word SHALL be loaded and in_data_valid SHALL remain 1 with no overrun.
REQ-026 out_data SHALL be captured into the TX holding register on out_data_valid & out_data_ready; out_data_ready SHALL drop the next clock.
REQ-027 At each word start (chip-select fall, or the sample edge completing a word), the TX shift register SHALL load the holding register and free it (out_data_ready=1), or load FILL_WORD if the holding register is empty.
REQ-028 With CPHA=0, the MSB SHALL be on SPI_out before the first leading edge; with CPHA=1, the MSB SHALL appear on the first leading edge; the following bits SHALL change on the shift edges.
REQ-029 On a chip-select rise mid-word, the partial RX word SHALL be discarded with no in_data_valid, the bit counter SHALL return to 0, and the TX holding register SHALL be retained.
REQ-030 SPI_out SHALL drive the TX shift MSB in all states; it SHALL NOT be tri-stated.

Reset
REQ-031 not_reset low SHALL immediately force: FSM IDLE, bit counter 0, in_data_valid 0, in_data 0, out_data_ready 1, TX holding/shift 0, rx_overrun 0, synchronisers to idle levels (SPI_clock=CPOL, chip select=1).
REQ-032 Reset deassertion mid-transfer SHALL NOT produce a word until a fresh chip-select fall is seen.

Configuration
REQ-033 Macro SPI_SLAVE_OVERRUN_EN SHALL enable overrun detection.
REQ-034 Defined: rx_overrun SHALL pulse for one clock on each REQ-025 conflict.
REQ-035 Undefined: rx_overrun SHALL be constant 0.
REQ-036 Defined: in the REQ-025 conflict, the held word SHALL be kept and the new word dropped.
REQ-037 Undefined: in the REQ-025 conflict, the new word SHALL overwrite in_data.

Verification
REQ-038 Mode 3, W=8, out_data=0xA5 loaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; in_data=0x3C with in_data_valid until ready.
REQ-039 Mode 0, W=16, out_data=0x8001, master sends 0x1234 -> MSB 1 present before the first SCK rise; in_data=0x1234.
REQ-040 No TX word loaded, FILL_WORD=0xFF -> MISO stays 1 for all 8 bits; out_data_ready stays 1.
REQ-041 Two words 0x11,0x22 with in_data_ready=0 -> macro defined: in_data=0x11 and one rx_overrun pulse; undefined: in_data=0x22 and no pulse.
REQ-042 Chip select raised after 5 bits, then a full 0x5A is sent -> no valid for the partial word; the next in_data=0x5A.
REQ-043 not_reset pulsed low mid-word -> all outputs at reset values within the same cycle; no valid until the next chip-select fall.

Source files
------------

// File: rtl/spi_slave_word.sv
// spi_slave_word: SPI slave that moves whole DATA_WIDTH-bit words between an
// SPI master and a pair of valid/ready streams in the system clock domain.
//
// Parameters:
//   DATA_WIDTH  bits per SPI word (2..32)
//   CPOL        SPI_clock idle level
//   CPHA        0: sample on leading edge, 1: sample on trailing edge
//   FILL_WORD   word shifted out when no TX word has been loaded
// Ports:
//   clock, not_reset          system clock (rising edge), async active-low reset
//   SPI_clock, SPI_in         serial clock / MOSI from master (asynchronous)
//   SPI_not_chip_select       active-low select from master (asynchronous)
//   SPI_out                   MISO, always driven with the TX shift MSB
//   in_data_valid/in_data     received word, held until in_data_ready
//   in_data_ready             consumer accepts in_data
//   out_data_valid/out_data   word offered for transmission
//   out_data_ready            TX holding register empty
//   active                    synchronised chip select is low
//   rx_overrun                one-cycle pulse when a received word is lost
// Build option:
//   SPI_SLAVE_OVERRUN_EN      keep the held word on an RX conflict and pulse
//                             rx_overrun; otherwise the new word overwrites it
//                             and rx_overrun is tied low.

module spi_slave_word #(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter bit                     CPOL       = 1'b1,
    parameter bit                     CPHA       = 1'b1,
    parameter logic [DATA_WIDTH-1:0]  FILL_WORD  = '1
) (
    input  logic                  clock,
    input  logic                  not_reset,
    input  logic                  SPI_clock,
    input  logic                  SPI_in,
    output logic                  SPI_out,
    input  logic                  SPI_not_chip_select,
    output logic                  in_data_valid,
    output logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_data_ready,
    input  logic                  out_data_valid,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_data_ready,
    output logic                  active,
    output logic                  rx_overrun
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t state_q, state_d;

    logic sck_s1, sck_s2, sck_q;
    logic mosi_s1, mosi_s2;
    logic cs_s1, cs_s2, cs_q;
    logic [1:0] settle_q;
    logic cs_armed_q;

    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] tx_hold_q;

    // Synchronisers plus one extra stage for edge detection
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            sck_s1  <= CPOL;
            sck_s2  <= CPOL;
            sck_q   <= CPOL;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_q    <= 1'b1;
            active  <= 1'b0;
        end else begin
            sck_s1  <= SPI_clock;
            sck_s2  <= sck_s1;
            sck_q   <= sck_s2;
            mosi_s1 <= SPI_in;
            mosi_s2 <= mosi_s1;
            cs_s1   <= SPI_not_chip_select;
            cs_s2   <= cs_s1;
            cs_q    <= cs_s2;
            active  <= ~cs_s1;
        end
    end

    // A chip-select fall only counts once a real high level has been seen
    // after reset, so a select still low from before reset starts nothing.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            settle_q   <= 2'd0;
            cs_armed_q <= 1'b0;
        end else begin
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd3 && cs_s2) begin
                cs_armed_q <= 1'b1;
            end
        end
    end

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, in_xfer;
    logic sample, shift, word_done, word_start;
    logic [DATA_WIDTH-1:0] rx_next;

    assign lead_edge   = (sck_q == CPOL) && (sck_s2 != CPOL);
    assign trail_edge  = (sck_q != CPOL) && (sck_s2 == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = cs_armed_q & cs_q & ~cs_s2;
    assign cs_rise     = ~cs_q & cs_s2;
    assign in_xfer     = (state_q == XFER) && !cs_rise;
    assign sample      = in_xfer && sample_edge;
    // The first shift edge of each word is skipped: the MSB is already out.
    assign shift       = in_xfer && shift_edge && (bit_cnt_q != '0);
    assign word_done   = sample && (bit_cnt_q == LAST_BIT);
    assign word_start  = ((state_q == IDLE) && cs_fall) || word_done;
    assign rx_next     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2};

    // FSM state register
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (state_q == IDLE && cs_fall) begin
            state_d = XFER;
        end
    end

    // Bit counter and RX shift register
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else if (state_q != XFER || cs_rise) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else if (sample) begin
            bit_cnt_q  <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
            rx_shift_q <= rx_next;
        end
    end

    // TX holding and shift registers; out_data_ready marks the holding register empty
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            tx_hold_q      <= '0;
            tx_shift_q     <= '0;
            out_data_ready <= 1'b1;
        end else begin
            if (word_start) begin
                tx_shift_q <= out_data_ready ? FILL_WORD : tx_hold_q;
            end else if (shift) begin
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (out_data_valid && out_data_ready) begin
                tx_hold_q      <= out_data;
                out_data_ready <= 1'b0;
            end else if (word_start && !out_data_ready) begin
                out_data_ready <= 1'b1;
            end
        end
    end

    assign SPI_out = tx_shift_q[DATA_WIDTH-1];

    logic rx_conflict;
    assign rx_conflict = word_done && in_data_valid && !in_data_ready;

    // Received-word output register
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            in_data       <= '0;
            in_data_valid <= 1'b0;
        end else if (word_done) begin
            in_data_valid <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
            if (!rx_conflict) begin
                in_data <= rx_next;
            end
`else
            in_data <= rx_next;
`endif
        end else if (in_data_valid && in_data_ready) begin
            in_data_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_conflict;
        end
    end
`else
    assign rx_overrun = 1'b0;
`endif

endmodule
